// File: rtl/dispatchu_pq.sv
// Instruction fetch/dispatch front end with a DEPTH-entry prefetch queue and one outstanding fetch.
// Define DISPATCHU_PQ_BYPASS_EN to forward an ack straight to issue when the queue is empty.
module dispatchu_pq #(
  parameter int DW = 16,
  parameter int AW = 32,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_req,
  output logic [AW-1:0]          mem_addr,
  input  logic                   mem_ack,
  input  logic [DW-1:0]          mem_rdata,
  input  logic                   redir_valid,
  input  logic [AW-1:0]          redir_pc,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [3:0]             iss_op,
  output logic [2:0]             iss_a,
  output logic [2:0]             iss_b,
  output logic [2:0]             iss_c,
  output logic [DW-1:0]          iss_word,
  output logic [AW-1:0]          iss_pc,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetchState_t;

  fetchState_t   state;
  logic [AW-1:0] fetchPc;
  logic [DW-1:0] wordMem [DEPTH];
  logic [AW-1:0] pcMem [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic          ackLive, push, pop, bypass, bypassTake;
  logic [CW-1:0] nextOcc;
  logic [DW-1:0] srcWord;
  logic [AW-1:0] srcPc;

  assign ackLive = mem_ack && (state == REQ);
  assign pop     = (q_count != '0) && iss_ready;
`ifdef DISPATCHU_PQ_BYPASS_EN
  assign bypass  = ackLive && (q_count == '0) && !redir_valid;
`else
  assign bypass  = 1'b0;
`endif
  assign bypassTake = bypass && iss_ready;
  assign push       = ackLive && !redir_valid && !bypassTake;
  // Refill decision ignores a same-cycle pop so a push can never overflow.
  assign nextOcc    = q_count + CW'(push);

  always_ff @(posedge clk) begin
    if (push) begin
      wordMem[wrPtr] <= mem_rdata;
      pcMem[wrPtr]   <= mem_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      q_count <= '0;
    end else if (redir_valid) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      q_count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      fetchPc  <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redir_valid) begin
            fetchPc <= redir_pc;
          end else if (q_count < DEPTH_C) begin
            mem_req  <= 1'b1;
            mem_addr <= fetchPc;
            state    <= REQ;
          end
        end
        REQ: begin
          if (redir_valid) begin
            fetchPc <= redir_pc;
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end else begin
              state   <= DRAIN;
            end
          end else if (mem_ack) begin
            fetchPc <= fetchPc + AW'(1);
            if (nextOcc < DEPTH_C) begin
              mem_addr <= fetchPc + AW'(1);
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        DRAIN: begin
          // The request stays on the bus until acked; its data is thrown away.
          if (redir_valid) fetchPc <= redir_pc;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    iss_valid = (q_count != '0);
    srcWord   = iss_valid ? wordMem[rdPtr] : '0;
    srcPc     = iss_valid ? pcMem[rdPtr] : '0;
    if (bypass) begin
      iss_valid = 1'b1;
      srcWord   = mem_rdata;
      srcPc     = mem_addr;
    end
  end

  assign iss_op   = srcWord[15:12];
  assign iss_a    = srcWord[11:9];
  assign iss_b    = srcWord[8:6];
  assign iss_c    = srcWord[5:3];
  assign iss_word = srcWord;
  assign iss_pc   = srcPc;
endmodule
